// File: rtl/mc_cpu_core_if.sv
// mc_cpu_core_if: instruction and data memory request/acknowledge buses
interface mc_cpu_core_if #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 10
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;
  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multi-cycle FETCH/DECODE/EXEC/MEM/WB core; define CPU_PERF_EN for cycle/retired counters
module mc_cpu_core #(
  parameter int          DATA_W   = 18,
  parameter int          ADDR_W   = 10,
  parameter int          NREG     = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  mc_cpu_core_if.master     bus,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        flags
`ifdef CPU_PERF_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       retired_cnt
`endif
);
  localparam int RW = NREG > 1 ? $clog2(NREG) : 1;
  localparam int IW = DATA_W - 12;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state, nxt;
  logic [DATA_W-1:0] rf [NREG];
  logic [DATA_W-1:0] ir, a, b, d, res, imm, alu, dwdata;
  logic [DATA_W:0]   add_r;
  logic [ADDR_W-1:0] daddr;
  logic [3:0]        op;
  logic [RW-1:0]     rd_i, rs1_i, rs2_i;
  logic              alu_c, taken;
  assign op    = ir[DATA_W-1 -: 4];
  assign rd_i  = ir[DATA_W-8 +: RW];
  assign rs1_i = ir[DATA_W-12 +: RW];
  assign rs2_i = ir[DATA_W-16 +: RW];
  assign imm   = {{12{ir[IW-1]}}, ir[IW-1:0]};
  assign add_r = {1'b0, a} + {1'b0, op == 4'd0 ? b : imm};
  assign taken = op == 4'd10 || (op == 4'd11 && flags[0]) || (op == 4'd12 && flags[1]) || (op == 4'd13 && flags[2]);
  assign bus.imem_req   = state == FETCH && !reset;
  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = state == MEM;
  assign bus.dmem_we    = state == MEM && op == 4'd9;
  assign bus.dmem_addr  = daddr;
  assign bus.dmem_wdata = dwdata;
  assign halted         = state == HALT;
  // ALU result and carry/borrow for the op held in ir
  always_comb begin
    alu = add_r[DATA_W-1:0];
    case (op)
      4'd1: alu = a - b;
      4'd3: alu = a & b;
      4'd4: alu = a | b;
      4'd5: alu = a ^ b;
      4'd6: alu = a << imm[3:0];
      4'd7: alu = a >> imm[3:0];
      default: alu = add_r[DATA_W-1:0];
    endcase
    alu_c = (op == 4'd0 || op == 4'd2) ? add_r[DATA_W] : op == 4'd1 ? a < b : 1'b0;
  end
  // next-state decode; memory phases wait for their ack
  always_comb begin
    nxt = state;
    case (state)
      FETCH:  nxt = bus.imem_ack ? DECODE : FETCH;
      DECODE: nxt = EXEC;
      EXEC:   nxt = !op[3] ? WB : (op == 4'd8 || op == 4'd9) ? MEM : op == 4'd15 ? HALT : FETCH;
      MEM:    nxt = !bus.dmem_ack ? MEM : op == 4'd8 ? WB : FETCH;
      WB:     nxt = FETCH;
      default: nxt = HALT;
    endcase
  end
  // state, PC, flags, operand latches and register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= FETCH;
      pc     <= ADDR_W'(RESET_PC);
      flags  <= '0;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      d      <= '0;
      res    <= '0;
      daddr  <= '0;
      dwdata <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      state <= nxt;
      case (state)
        FETCH: if (bus.imem_ack) ir <= bus.imem_rdata;
        DECODE: begin
          a <= rf[rs1_i];
          b <= rf[rs2_i];
          d <= rf[rd_i];
        end
        EXEC: begin
          if (!op[3]) begin
            res   <= alu;
            flags <= {alu[DATA_W-1], alu_c, alu == '0};
          end
          if (op == 4'd8 || op == 4'd9) begin
            daddr  <= add_r[ADDR_W-1:0];
            dwdata <= d;
          end
          if (op >= 4'd10 && op <= 4'd14) pc <= taken ? ir[ADDR_W-1:0] : pc + 1'b1;
        end
        MEM: if (bus.dmem_ack) begin
          res <= bus.dmem_rdata;
          if (op == 4'd9) pc <= pc + 1'b1;
        end
        WB: begin
          if (rd_i != '0) rf[rd_i] <= res;
          pc <= pc + 1'b1;
        end
        default: ;
      endcase
    end
  end
`ifdef CPU_PERF_EN
  // cycle and retired-instruction counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if (state != HALT) cycle_cnt <= cycle_cnt + 1'b1;
      if ((nxt == FETCH && (state == EXEC || state == MEM || state == WB)) || (state == EXEC && nxt == HALT))
        retired_cnt <= retired_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_mc_cpu_core.sv
// tb_mc_cpu_core: directed programs with a scoreboard of expected data accesses and halt state
module tb_mc_cpu_core;
  localparam int DW = 18;
  localparam int AW = 10;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  mc_cpu_core_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
  logic          halted;
  logic [AW-1:0] pc;
  logic [2:0]    flags;
  mc_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .NREG(16), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .bus(bus), .halted(halted), .pc(pc), .flags(flags)
  );
  logic [DW-1:0] imem [0:1023];
  logic [DW-1:0] dmem [0:1023];
  int idelay = 0, ddelay = 0, icnt = 0, dcnt = 0, stall_addr = -1;
  logic ipulse = 0, dpulse = 0;
  assign bus.imem_ack   = (bus.imem_req && icnt >= idelay && int'(bus.imem_addr) != stall_addr) || ipulse;
  assign bus.imem_rdata = imem[bus.imem_addr];
  assign bus.dmem_ack   = (bus.dmem_req && dcnt >= ddelay) || dpulse;
  assign bus.dmem_rdata = dmem[bus.dmem_addr];
  // memory model: wait-state counters and store writes
  always @(posedge clk) begin
    icnt <= (bus.imem_req && !bus.imem_ack) ? icnt + 1 : 0;
    dcnt <= (bus.dmem_req && !bus.dmem_ack) ? dcnt + 1 : 0;
    if (bus.dmem_req && bus.dmem_ack && bus.dmem_we) dmem[bus.dmem_addr] <= bus.dmem_wdata;
  end
  typedef struct {bit halt; bit we; int addr; int data; int cyc;} exp_t;
  exp_t sb[$];
  exp_t me;
  int checks = 0, errors = 0, cyc = 0, run_len = 0;
  bit unstable = 0, hq = 0;
  logic [AW-1:0] a0;
  logic [DW-1:0] w0;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // monitor: pops the scoreboard on each completed data access and on halt
  always @(negedge clk) begin
    if (reset) begin
      run_len = 0;
      hq = 0;
      unstable = 0;
    end else begin
      if (bus.dmem_req) begin
        if (run_len == 0) begin
          a0 = bus.dmem_addr;
          w0 = bus.dmem_wdata;
          unstable = 0;
        end else if (bus.dmem_addr != a0 || bus.dmem_wdata != w0) unstable = 1;
        run_len++;
        if (bus.dmem_ack) begin
          if (sb.size() == 0 || sb[0].halt) begin
            checks++;
            errors++;
            $display("FAIL dmem_unexpected: access at addr %0h with none expected", bus.dmem_addr);
          end else begin
            me = sb.pop_front();
            chk("dmem_we", bus.dmem_we, me.we);
            chk("dmem_addr", bus.dmem_addr, me.addr);
            chk("dmem_data", bus.dmem_we ? bus.dmem_wdata : bus.dmem_rdata, me.data);
            chk("dmem_req_cycles", run_len, me.cyc);
            chk("dmem_stable", unstable, 0);
          end
          run_len = 0;
        end
      end else run_len = 0;
      if (halted && !hq) begin
        if (sb.size() == 0 || !sb[0].halt) begin
          checks++;
          errors++;
          $display("FAIL halt_unexpected: halted at pc %0h before expected accesses", pc);
        end else begin
          me = sb.pop_front();
          chk("halt_pc", pc, me.addr);
          chk("halt_flags", flags, me.data);
          chk("halt_cycles", cyc, me.cyc);
        end
      end
      hq = halted;
    end
  end
  function automatic logic [DW-1:0] ins(input int op, input int rd, input int rs1, input int imm);
    return {op[3:0], rd[3:0], rs1[3:0], imm[5:0]};
  endfunction
  function automatic logic [DW-1:0] rr(input int op, input int rd, input int rs1, input int rs2);
    return ins(op, rd, rs1, rs2 * 4);
  endfunction
  function automatic logic [DW-1:0] jt(input int op, input int t);
    return {op[3:0], 4'b0, t[9:0]};
  endfunction
  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) imem[i] = ins(15, 0, 0, 0);
  endtask
  task automatic push_mem(input bit we, input int addr, input int data, input int rc);
    sb.push_back('{halt: 0, we: we, addr: addr, data: data, cyc: rc});
  endtask
  task automatic push_halt(input int hpc, input int fl, input int c);
    sb.push_back('{halt: 1, we: 0, addr: hpc, data: fl, cyc: c});
  endtask
  task automatic run(input int budget, input bit dp);
    int n;
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    n = 0;
    if (dp) begin
      dpulse = 1;
      @(negedge clk);
      dpulse = 0;
      n = 1;
    end
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!halted) begin
      checks++;
      errors++;
      $display("FAIL halt_timeout: no halt within %0d cycles", budget);
    end
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    sb.delete();
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) dmem[i] = '0;
    clear_prog();
    @(negedge clk);
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_dmem_req", bus.dmem_req, 0);
    chk("rst_dmem_we", bus.dmem_we, 0);
    chk("rst_imem_addr", bus.imem_addr, 0);
    chk("rst_dmem_addr", bus.dmem_addr, 0);
    chk("rst_dmem_wdata", bus.dmem_wdata, 0);
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_flags", flags, 0);
    // ADDI/ADDI/ADD/HALT, zero wait: halts at cycle 15
    imem[0] = ins(2, 1, 0, 5);
    imem[1] = ins(2, 2, 0, 3);
    imem[2] = rr(0, 3, 1, 2);
    push_halt(3, 3'b000, 15);
    run(100, 0);
    repeat (3) @(negedge clk);
    chk("halt_imem_req", bus.imem_req, 0);
    chk("halt_dmem_req", bus.dmem_req, 0);
    chk("halt_stays", halted, 1);
    // same sum stored out, two fetch wait states per instruction
    clear_prog();
    idelay = 2;
    imem[0] = ins(2, 1, 0, 5);
    imem[1] = ins(2, 2, 0, 3);
    imem[2] = rr(0, 3, 1, 2);
    imem[3] = ins(9, 3, 0, 10);
    push_mem(1, 10, 8, 1);
    push_halt(4, 3'b000, 29);
    run(200, 0);
    idelay = 0;
    // SUB to zero then BZ taken
    clear_prog();
    imem[0] = ins(2, 1, 0, 7);
    imem[1] = rr(1, 1, 1, 1);
    imem[2] = jt(11, 'h20);
    push_halt('h20, 3'b001, 14);
    run(100, 0);
    // ADD overflow 0x3FFFF+1: Z=1 C=1, BC taken, BN not taken
    clear_prog();
    imem[0] = ins(2, 1, 0, 63);
    imem[1] = ins(2, 2, 0, 1);
    imem[2] = rr(0, 3, 1, 2);
    imem[3] = jt(12, 'h30);
    imem['h30] = jt(13, 'h40);
    imem['h31] = ins(9, 3, 0, 5);
    push_mem(1, 5, 0, 1);
    push_halt('h32, 3'b011, 25);
    run(100, 0);
    // r0 write discarded, SUB borrow 2-5
    clear_prog();
    imem[0] = ins(2, 0, 0, 5);
    imem[1] = ins(9, 0, 0, 8);
    imem[2] = ins(2, 1, 0, 2);
    imem[3] = ins(2, 2, 0, 5);
    imem[4] = rr(1, 3, 1, 2);
    imem[5] = ins(9, 3, 0, 6);
    push_mem(1, 8, 0, 1);
    push_mem(1, 6, 'h3FFFD, 1);
    push_halt(6, 3'b110, 27);
    run(100, 0);
    // logic and shift ops
    clear_prog();
    imem[0] = ins(2, 1, 0, 22);
    imem[1] = ins(2, 2, 0, 56);
    imem[2] = rr(3, 3, 1, 2);
    imem[3] = rr(4, 4, 1, 2);
    imem[4] = rr(5, 5, 1, 2);
    imem[5] = ins(6, 6, 1, 3);
    imem[6] = ins(7, 7, 2, 4);
    for (int i = 0; i < 5; i++) imem[7+i] = ins(9, 3 + i, 0, 20 + i);
    push_mem(1, 20, 'h10, 1);
    push_mem(1, 21, 'h3FFFE, 1);
    push_mem(1, 22, 'h3FFEE, 1);
    push_mem(1, 23, 'hB0, 1);
    push_mem(1, 24, 'h3FFF, 1);
    push_halt(12, 3'b000, 51);
    run(200, 0);
    // ST then LD with three data wait states each
    clear_prog();
    ddelay = 3;
    imem[0] = ins(2, 5, 0, 13);
    imem[1] = ins(9, 5, 0, 4);
    imem[2] = ins(8, 6, 0, 4);
    imem[3] = ins(9, 6, 0, 7);
    push_mem(1, 4, 13, 4);
    push_mem(0, 4, 13, 4);
    push_mem(1, 7, 13, 4);
    push_halt(4, 3'b000, 29);
    run(200, 0);
    ddelay = 0;
    // JMP 0x3FF, NOP wraps PC to 0, BZ then taken
    clear_prog();
    imem[0] = jt(11, 'h10);
    imem[1] = rr(1, 1, 1, 1);
    imem[2] = jt(10, 'h3FF);
    imem['h3FF] = ins(14, 0, 0, 0);
    push_halt('h10, 3'b001, 19);
    run(100, 0);
    // reset while a fetch is stalled
    clear_prog();
    imem[0] = ins(2, 1, 0, 9);
    imem[1] = ins(2, 2, 0, 63);
    stall_addr = 2;
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (12) @(negedge clk);
    chk("stall_imem_req", bus.imem_req, 1);
    chk("stall_imem_addr", bus.imem_addr, 2);
    chk("stall_flags", flags, 3'b100);
    #2 reset = 1;
    #1;
    chk("midrst_imem_req", bus.imem_req, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_flags", flags, 0);
    ipulse = 1;
    @(negedge clk);
    ipulse = 0;
    chk("midrst_ack_ignored", pc, 0);
    stall_addr = -1;
    clear_prog();
    imem[0] = ins(9, 1, 0, 3);
    imem[1] = ins(9, 2, 0, 4);
    push_mem(1, 3, 0, 1);
    push_mem(1, 4, 0, 1);
    push_halt(2, 3'b000, 11);
    run(100, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_cpu_core.md
# mc_cpu_core

Parametrised multi-cycle CPU core: next-generation replacement for the single-cycle 18-bit core. It has a FETCH/DECODE/EXEC/MEM/WB state machine, stall-capable request/acknowledge memory ports, a flags register with conditional branches, and configurable data width, address width and register count. It sits at the top of the processor hierarchy and drives the external instruction and data memories.

## Interface
- DATA_W, 18, datapath and instruction width (≥16)
- ADDR_W, 10, memory address width (≤ DATA_W−4)
- NREG, 16, register count (power of 2, ≤16; register field is 4 bits, upper bits ignored)
- RESET_PC, 0, PC value after reset
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- imem_req  out  1  instruction fetch request
- imem_addr  out  ADDR_W  fetch address (= PC)
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  DATA_W  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  ADDR_W  data address
- dmem_wdata  out  DATA_W  store data
- dmem_ack  in  1  access complete; load data valid
- dmem_rdata  in  DATA_W  load data
- halted  out  1  core stopped on HALT
- pc  out  ADDR_W  current PC
- flags  out  3  {N,C,Z}

## Operation
- Instruction fields: op=[DATA_W−1:DATA_W−4], rd=[DATA_W−5:DATA_W−8], rs1=[DATA_W−9:DATA_W−12], rs2=[DATA_W−13:DATA_W−16], imm = low DATA_W−12 bits, sign-extended; target = low ADDR_W bits.
- Opcodes: 0 ADD, 1 SUB, 2 ADDI (rs1+imm), 3 AND, 4 OR, 5 XOR, 6 SHL (rs1<<imm[3:0]), 7 SHR logical, 8 LD rd=mem[rs1+imm], 9 ST mem[rs1+imm]=rd, 10 JMP, 11 BZ, 12 BC, 13 BN, 14 NOP, 15 HALT.
- r0 reads as zero; writes to r0 are discarded.
- Flags are updated only by ops 0–7. Z = result==0; N = result MSB. C = carry out for ADD/ADDI, borrow (rs1<rs2 unsigned) for SUB, 0 for all other ops.
- Arithmetic is modulo 2^DATA_W. The data address is (rs1+imm)[ADDR_W−1:0].
- States:
  - FETCH: imem_req held high until imem_ack, then instruction latched → DECODE.
  - DECODE: register reads → EXEC.
  - EXEC:
    - ALU ops → WB.
    - LD/ST → MEM.
    - JMP/taken branch: PC=target → FETCH.
    - Not-taken branch/NOP: PC+1 → FETCH.
    - HALT → HALT.
  - MEM: dmem_req held high until dmem_ack.
    - Load → WB.
    - Store: PC+1 → FETCH.
  - WB: rd written, PC+1 → FETCH.
  - HALT: terminal; leaves only on reset.
- PC increment wraps 2^ADDR_W−1 → 0.

## Timing
- Reset values:
  - state=FETCH, pc=RESET_PC, all registers and flags 0, halted=0.
  - All req/we outputs 0.
  - imem_addr = RESET_PC; dmem_addr/wdata = 0.
- Reset mid-access drops the outstanding request immediately; a late ack is ignored.
- Ack is sampled in the same cycle as req. With zero-wait memory:
  - ALU op: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - Branch/JMP/NOP: 3 cycles.
- Each wait cycle (req high, ack low) adds one cycle. Address and data outputs stay stable while req is high.
- An ack arriving while req is low is ignored.
- halted asserts the cycle after EXEC of HALT. All req outputs stay low thereafter.
- Flags become visible the cycle after EXEC. A branch immediately following an ALU op sees the updated flags.

## Configuration
- CPU_PERF_EN defined:
  - Adds outputs cycle_cnt[31:0] and retired_cnt[31:0], both reset to 0.
  - cycle_cnt increments every non-HALT cycle.
  - retired_cnt increments once per completed instruction (entry to FETCH from EXEC/MEM/WB, and on the HALT transition).
  - Both wrap at 2^32.
- CPU_PERF_EN undefined: ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Zero-wait memory, program ADDI r1,r0,5; ADDI r2,r0,3; ADD r3,r1,r2; HALT → r3=8, Z=0, halted after 4+4+4+3=15 cycles.
- SUB r1,r1,r1 with r1=7, then BZ 0x20 → flags Z=1,C=0; pc=0x20 after the branch.
- ADD of 0x3FFFF+1 (DATA_W=18) → result 0, Z=1, C=1; BC taken.
- ST r5→[r0+4], then LD r6←[r0+4], with dmem_ack delayed 3 cycles each → r6=r5; dmem_req held 4 cycles per access, address 4 stable throughout.
- JMP to 0x3FF, NOP at 0x3FF → PC wraps to 0x000.
- Reset asserted while imem_req is waiting for ack → req drops immediately, pc=RESET_PC, registers 0; an ack pulse arriving during reset has no effect.
